// File: rtl/pipeline_sequencer_if.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer_if
//   Bundles the datapath-facing signals of pipeline_sequencer. Clock and reset
//   stay as plain ports on the module.
//
//   Datapath -> sequencer (inputs of the master modport):
//     stall_request        memory unit needs another cycle; current stage holds
//     halt_request         stop after the current instruction retires
//     decoding_error       instruction in WRITEBACK is illegal
//     new_program_counter  next PC from pc_mux, valid in WRITEBACK
//     wb_rd_write_enabled  rd_mux says the instruction writes rd
//   Sequencer -> datapath (outputs of the master modport):
//     program_counter      address of the instruction being fetched
//     stage_enable         one-hot [0]FETCH [1]DECODE [2]EXECUTE [3]WRITEBACK
//     rd_commit_enable     one-cycle register-file write strobe
//     retired_count        retired instruction count (wraps)
//     halted               high while halted
//     stall_timeout        sticky stall watchdog flag
//     trap                 high while trapped
// ---------------------------------------------------------------------------
interface pipeline_sequencer_if #(
  parameter int COUNTER_WIDTH = 32
);
  logic                     stall_request;
  logic                     halt_request;
  logic                     decoding_error;
  logic [31:0]              new_program_counter;
  logic                     wb_rd_write_enabled;
  logic [31:0]              program_counter;
  logic [3:0]               stage_enable;
  logic                     rd_commit_enable;
  logic [COUNTER_WIDTH-1:0] retired_count;
  logic                     halted;
  logic                     stall_timeout;
  logic                     trap;

  // The sequencer itself.
  modport master (
    input  stall_request, halt_request, decoding_error,
           new_program_counter, wb_rd_write_enabled,
    output program_counter, stage_enable, rd_commit_enable,
           retired_count, halted, stall_timeout, trap
  );

  // The datapath side that feeds and consumes the sequencer.
  modport slave (
    output stall_request, halt_request, decoding_error,
           new_program_counter, wb_rd_write_enabled,
    input  program_counter, stage_enable, rd_commit_enable,
           retired_count, halted, stall_timeout, trap
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
//   Four-phase datapath sequencer (FETCH, DECODE, EXECUTE, WRITEBACK) with
//   HALTED and TRAP states. Drives per-stage clock enables, owns the program
//   counter, gates register-file commits, counts retired instructions and
//   watches for memory stalls that last too long.
//
//   Ports:
//     clk    system clock, all state updates on posedge
//     reset  synchronous, active-high reset (wins over every other input)
//     bus    pipeline_sequencer_if.master (see the interface file for signals)
//
//   Parameters:
//     RESET_PC       program counter value loaded on reset
//     COUNTER_WIDTH  width of retired_count
//     STALL_TIMEOUT  consecutive stall cycles at which stall_timeout is set
//
//   Build option:
//     SEQUENCER_TRAP_EN  when defined, an illegal instruction or misaligned
//                        next PC at WRITEBACK completion enters TRAP, which only
//                        reset leaves. When undefined, decoding_error is ignored,
//                        trap stays 0 and misaligned PCs are masked to a word.
// ---------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0,
  parameter int          COUNTER_WIDTH = 32,
  parameter int          STALL_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_sequencer_if.master bus
);

  localparam int SCW = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT + 1);
  localparam logic [SCW-1:0]           STALL_MAX = SCW'(STALL_TIMEOUT);
  localparam logic [SCW-1:0]           STALL_ONE = SCW'(1);
  localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = COUNTER_WIDTH'(1);

  // Encodings 0..3 double as the stage_enable bit index of each stage.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALTED    = 3'd4,
    ST_TRAP      = 3'd5
  } state_t;

  state_t                   state_reg;
  state_t                   state_next;
  logic [31:0]              pc_reg;
  logic [3:0]               stage_enable_reg;
  logic                     rd_commit_enable_reg;
  logic [COUNTER_WIDTH-1:0] retired_count_reg;
  logic                     halted_reg;
  logic                     stall_timeout_reg;
  logic                     trap_reg;
  logic [SCW-1:0]           stall_cnt_reg;

  logic                     stage_active;
  logic                     wb_complete;
  logic                     trap_cond;
  logic [SCW-1:0]           stall_cnt_inc;
  logic [3:0]               stage_onehot_next;

  // Stalls only count while one of the four pipeline stages is running;
  // HALTED and TRAP ignore stall_request.
  assign stage_active  = (state_reg != ST_HALTED) && (state_reg != ST_TRAP);
  assign wb_complete   = (state_reg == ST_WRITEBACK) && !bus.stall_request;
  assign stall_cnt_inc = stall_cnt_reg + STALL_ONE;

`ifdef SEQUENCER_TRAP_EN
  assign trap_cond = bus.decoding_error || (bus.new_program_counter[1:0] != 2'b00);
`else
  assign trap_cond = 1'b0;
  // Without traps these bits are intentionally dropped.
  logic unused_trap_inputs;
  assign unused_trap_inputs = ^{bus.decoding_error, bus.new_program_counter[1:0]};
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:     if (!bus.stall_request) state_next = ST_DECODE;
      ST_DECODE:    if (!bus.stall_request) state_next = ST_EXECUTE;
      ST_EXECUTE:   if (!bus.stall_request) state_next = ST_WRITEBACK;
      ST_WRITEBACK: begin
        // A stall in WRITEBACK wins over halt; halt is looked at again on
        // the cycle the instruction actually completes.
        if (!bus.stall_request) begin
          if (trap_cond)             state_next = ST_TRAP;
          else if (bus.halt_request) state_next = ST_HALTED;
          else                       state_next = ST_FETCH;
        end
      end
      ST_HALTED:    if (!bus.halt_request) state_next = ST_FETCH;
      ST_TRAP:      state_next = ST_TRAP;
      default:      state_next = ST_FETCH;
    endcase
  end

  // stage_enable is registered from the next state so it always matches the
  // state it is reported alongside.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stage_onehot
      assign stage_onehot_next[gi] = (state_next == state_t'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg            <= ST_FETCH;
      pc_reg               <= RESET_PC;
      stage_enable_reg     <= 4'b0001;
      rd_commit_enable_reg <= 1'b0;
      retired_count_reg    <= '0;
      halted_reg           <= 1'b0;
      stall_timeout_reg    <= 1'b0;
      trap_reg             <= 1'b0;
      stall_cnt_reg        <= '0;
    end else begin
      state_reg            <= state_next;
      stage_enable_reg     <= stage_onehot_next;
      halted_reg           <= (state_next == ST_HALTED);
      trap_reg             <= (state_next == ST_TRAP);
      rd_commit_enable_reg <= 1'b0;

      // Retirement: the commit strobe lands in the cycle after WRITEBACK.
      if (wb_complete && !trap_cond) begin
        pc_reg               <= {bus.new_program_counter[31:2], 2'b00};
        retired_count_reg    <= retired_count_reg + COUNT_ONE;
        rd_commit_enable_reg <= bus.wb_rd_write_enabled;
      end

      // Stall watchdog: saturating counter, sticky flag.
      if (bus.stall_request && stage_active) begin
        if (stall_cnt_reg != STALL_MAX) begin
          stall_cnt_reg <= stall_cnt_inc;
          if (stall_cnt_inc == STALL_MAX) stall_timeout_reg <= 1'b1;
        end
      end else begin
        stall_cnt_reg <= '0;
      end
    end
  end

  assign bus.program_counter  = pc_reg;
  assign bus.stage_enable     = stage_enable_reg;
  assign bus.rd_commit_enable = rd_commit_enable_reg;
  assign bus.retired_count    = retired_count_reg;
  assign bus.halted           = halted_reg;
  assign bus.stall_timeout    = stall_timeout_reg;
  assign bus.trap             = trap_reg;

endmodule
